// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM state
// encodings and the request legality check.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // funct3[1:0] encodes the access size for every legal code: 00 byte, 01 half, 10 word.
    function automatic logic req_err(input logic store, input logic [2:0] funct3,
                                     input logic [1:0] offset);
        logic illegal;
        logic misaligned;
        if (store)
            illegal = !(funct3 == F3_SB || funct3 == F3_SH || funct3 == F3_SW);
        else
            illegal = !(funct3 == F3_LB || funct3 == F3_LH || funct3 == F3_LW ||
                        funct3 == F3_LBU || funct3 == F3_LHU);
        misaligned = (funct3[1:0] == 2'b01 && offset[0]) ||
                     (funct3[1:0] == 2'b10 && offset != 2'b00);
        return illegal || misaligned;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load data extraction and sign/zero extension; also reusable
// on instruction-fetch byte paths.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_offset,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_data[{i_offset, 3'b000} +: 8];
        w_half = i_offset[1] ? i_data[31:16] : i_data[15:0];
        case (i_funct3)
            F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_data = {{16{w_half[15]}}, w_half};
            F3_LW:   o_data = i_data;
            F3_LBU:  o_data = {24'd0, w_byte};
            F3_LHU:  o_data = {16'd0, w_half};
            default: o_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single outstanding request, byte-lane store generation,
// one-cycle synchronous memory read latency, registered response.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_LSB = 2,
    parameter int MEM_AW   = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout
);

    logic [1:0]  r_state;
    logic        r_store;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_err;
    logic [1:0]  w_off;
    logic [31:0] w_load_data;
    logic [3:0]  w_we;
    logic [31:0] w_din;
    logic        w_issue;
    logic        w_unused;

    assign w_off    = r_addr[1:0];
    assign w_err    = req_err(req_store, req_funct3, req_addr[1:0]);
    // Upper address bits are deliberately dropped; the memory aliases.
    assign w_unused = ^{r_addr[31:ADDR_LSB+MEM_AW], req_addr[31:2]};

    lsu_load_align u_load_align (
        .i_data   (mem_dout),
        .i_funct3 (r_funct3),
        .i_offset (w_off),
        .o_data   (w_load_data)
    );

    always_comb begin
        w_we  = 4'b0000;
        w_din = 32'd0;
        case (r_funct3)
            F3_SB: begin
                w_we  = 4'b0001 << w_off;
                w_din = {4{r_wdata[7:0]}};
            end
            F3_SH: begin
                w_we  = 4'b0011 << w_off;
                w_din = {2{r_wdata[15:0]}};
            end
            F3_SW: begin
                w_we  = 4'b1111;
                w_din = r_wdata;
            end
            default: begin
                w_we  = 4'b0000;
                w_din = 32'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_store  <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_store  <= req_store;
                        r_funct3 <= req_funct3;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_rdata  <= 32'd0;
                        r_err    <= w_err;
                        r_state  <= w_err ? ST_RESP : ST_ISSUE;
                    end
                end
                ST_ISSUE: r_state <= r_store ? ST_RESP : ST_WAIT;
                ST_WAIT: begin
                    r_rdata <= w_load_data;
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Enables are gated by rst so a store caught by reset never commits.
    assign w_issue    = (r_state == ST_ISSUE) && !rst;
    assign req_ready  = (r_state == ST_IDLE);
    assign resp_valid = (r_state == ST_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
    assign mem_en     = w_issue;
    assign mem_we     = (w_issue && r_store) ? w_we : 4'b0000;
    assign mem_din    = (r_state == ST_ISSUE && r_store) ? w_din : 32'd0;
    assign mem_addr   = r_addr[ADDR_LSB+MEM_AW-1:ADDR_LSB];

endmodule
